uart_result_serializer: RTL and testbench

Parametrised result-to-UART serializer between the systolic array output (data_out/data_out_valid) and the UART transmitter (transmit/data/tx_done).
It buffers full-width results in a FIFO so back-to-back results are not lost. Each result is split into ceil(RESULT_W/8) bytes, optionally preceded by a sync byte, and the bytes are paced by the transmitter's tx_done handshake.
It replaces "send lower 8 bits on rising valid edge", which truncates results and drops any result arriving while TX is busy.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_result_serializer.sv | 142 ++++++++++++++
 tb/tb_uart_result_serializer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the result-to-UART serializer: FSM encoding,
// default frame header and a ceiling-divide helper for byte counts.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_WAIT_S,
        ST_BYTE,
        ST_WAIT_B
    } ser_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Pushes while full and pops
// while empty are ignored; full/empty are derived from the registered count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_result_serializer.sv
// Buffers full-width results and sends each one as an optional sync byte
// followed by ceil(RESULT_W/8) data bytes, one byte per tx_done handshake.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for a buffered result; pops the head when present
//  ST_SYNC   | presents the frame header and pulses tx_start
//  ST_WAIT_S | header in flight; waits for tx_done
//  ST_BYTE   | presents data byte idx and pulses tx_start
//  ST_WAIT_B | data byte in flight; waits for tx_done, then next or idle
module uart_result_serializer
    import uart_pkg::*;
#(
    parameter int         RESULT_W   = 21,
    parameter int         FIFO_DEPTH = 8,
    parameter int         MSB_FIRST  = 0,
    parameter int         SYNC_EN    = 1,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [RESULT_W-1:0]           res_data,
    input  logic                          res_valid,
    output logic [7:0]                    tx_data,
    output logic                          tx_start,
    input  logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          idle
);

    localparam int              NBYTES   = ceil_div(RESULT_W, 8);
    localparam int              IDXW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    ser_state_t             state;
    logic [IDXW-1:0]        idx;
    logic [IDXW-1:0]        sel_idx;
    logic [NBYTES*8-1:0]    word_q;
    logic [NBYTES*8-1:0]    head_ext;
    logic [RESULT_W-1:0]    head;
    logic [7:0]             cur_byte;
    logic                   full;
    logic                   empty;
    logic                   pop;

    assign pop = (state == ST_IDLE) && !empty;

    sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (res_valid),
        .wdata (res_data),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Zero-extend the FIFO head to a whole number of bytes.
    always_comb begin
        head_ext                = '0;
        head_ext[RESULT_W-1:0]  = head;
    end

    // Pick the byte for the current index in the configured byte order.
    always_comb begin
        sel_idx  = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;
        cur_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (sel_idx == IDXW'(i)) begin
                cur_byte = word_q[i*8 +: 8];
            end
        end
    end

    // Sticky drop flag: a push against a full FIFO is lost even if a pop
    // happens in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (res_valid && full) begin
            overflow <= 1'b1;
        end
    end

    // Frame sequencer with registered tx_data/tx_start/idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            word_q   <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            idle     <= 1'b1;
        end else begin
            tx_start <= 1'b0;
            idle     <= empty && (state == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        word_q <= head_ext;
                        idx    <= '0;
                        state  <= (SYNC_EN != 0) ? ST_SYNC : ST_BYTE;
                    end
                end
                ST_SYNC: begin
                    tx_data  <= SYNC_BYTE;
                    tx_start <= 1'b1;
                    state    <= ST_WAIT_S;
                end
                ST_WAIT_S: begin
                    if (tx_done) begin
                        idx   <= '0;
                        state <= ST_BYTE;
                    end
                end
                ST_BYTE: begin
                    tx_data  <= cur_byte;
                    tx_start <= 1'b1;
                    state    <= ST_WAIT_B;
                end
                ST_WAIT_B: begin
                    if (tx_done) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_BYTE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_serializer.sv
// Bench for the result serializer: two instances (LSB-first with header,
// MSB-first without), a transmitter model per instance and byte scoreboards.
module tb_uart_result_serializer;

    localparam int RW = 21;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;

    logic [RW-1:0] a_res_data  = '0;
    logic          a_res_valid = 1'b0;
    logic [7:0]    a_tx_data;
    logic          a_tx_start;
    logic          a_done_model = 1'b0;
    logic          a_spur       = 1'b0;
    logic [3:0]    a_fifo_count;
    logic          a_overflow;
    logic          a_idle;

    logic [RW-1:0] b_res_data  = '0;
    logic          b_res_valid = 1'b0;
    logic [7:0]    b_tx_data;
    logic          b_tx_start;
    logic          b_done_model = 1'b0;
    logic [3:0]    b_fifo_count;
    logic          b_overflow;
    logic          b_idle;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    int         a_delay = 3;
    bit         a_stall = 0;
    bit         a_dbl = 0;
    bit         a_dbl_pend = 0;
    bit         a_out = 0;
    bit         a_prev = 0;
    int         a_cnt = 0;
    int         a_bytes = 0;
    int         a_peak = 0;
    logic [7:0] a_held = '0;

    bit         b_out = 0;
    bit         b_prev = 0;
    int         b_cnt = 0;
    int         b_bytes = 0;
    logic [7:0] b_held = '0;

    always #5 clk = ~clk;

    uart_result_serializer dut_a (
        .clk        (clk),
        .reset      (reset),
        .res_data   (a_res_data),
        .res_valid  (a_res_valid),
        .tx_data    (a_tx_data),
        .tx_start   (a_tx_start),
        .tx_done    (a_done_model | a_spur),
        .fifo_count (a_fifo_count),
        .overflow   (a_overflow),
        .idle       (a_idle)
    );

    uart_result_serializer #(
        .MSB_FIRST (1),
        .SYNC_EN   (0)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .res_data   (b_res_data),
        .res_valid  (b_res_valid),
        .tx_data    (b_tx_data),
        .tx_start   (b_tx_start),
        .tx_done    (b_done_model),
        .fifo_count (b_fifo_count),
        .overflow   (b_overflow),
        .idle       (b_idle)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transmitter model A: one byte in flight, tx_done a_delay cycles after start.
    always @(negedge clk) begin
        a_done_model = 1'b0;
        if (reset) begin
            a_out      = 0;
            a_dbl_pend = 0;
            a_prev     = 0;
        end else begin
            if (a_dbl_pend) begin
                a_done_model = 1'b1;
                a_dbl_pend   = 0;
            end else if (a_out && !a_stall) begin
                if (a_cnt == 0) begin
                    check("a_hold", a_tx_data, a_held);
                    a_done_model = 1'b1;
                    a_out        = 0;
                    if (a_dbl) begin
                        a_dbl_pend = 1;
                        a_dbl      = 0;
                    end
                end else begin
                    a_cnt--;
                end
            end
            if (a_tx_start) begin
                if (a_prev) begin
                    check("a_start_width", a_tx_start, 1'b0);
                end else begin
                    if (a_out) check("a_overlap", a_out, 1'b0);
                    if (exp_a.size() == 0) check("a_extra_byte", {1'b1, a_tx_data}, 9'h0);
                    else check("a_byte", a_tx_data, exp_a.pop_front());
                    a_out  = 1;
                    a_cnt  = a_delay;
                    a_held = a_tx_data;
                    a_bytes++;
                end
            end
            a_prev = a_tx_start;
            if (int'(a_fifo_count) > a_peak) a_peak = int'(a_fifo_count);
        end
    end

    // Transmitter model B: fixed three-cycle byte time.
    always @(negedge clk) begin
        b_done_model = 1'b0;
        if (reset) begin
            b_out  = 0;
            b_prev = 0;
        end else begin
            if (b_out) begin
                if (b_cnt == 0) begin
                    check("b_hold", b_tx_data, b_held);
                    b_done_model = 1'b1;
                    b_out        = 0;
                end else begin
                    b_cnt--;
                end
            end
            if (b_tx_start && !b_prev) begin
                if (b_out) check("b_overlap", b_out, 1'b0);
                if (exp_b.size() == 0) check("b_extra_byte", {1'b1, b_tx_data}, 9'h0);
                else check("b_byte", b_tx_data, exp_b.pop_front());
                b_out  = 1;
                b_cnt  = 3;
                b_held = b_tx_data;
                b_bytes++;
            end
            b_prev = b_tx_start;
        end
    end

    task automatic drive_a(input logic [RW-1:0] w, input bit keep);
        logic [23:0] e;
        e = 24'(w);
        if (keep) begin
            exp_a.push_back(8'hA5);
            exp_a.push_back(e[7:0]);
            exp_a.push_back(e[15:8]);
            exp_a.push_back(e[23:16]);
        end
        a_res_data  = w;
        a_res_valid = 1'b1;
        @(posedge clk);
        #1;
        a_res_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [RW-1:0] w);
        logic [23:0] e;
        e = 24'(w);
        exp_b.push_back(e[23:16]);
        exp_b.push_back(e[15:8]);
        exp_b.push_back(e[7:0]);
        b_res_data  = w;
        b_res_valid = 1'b1;
        @(posedge clk);
        #1;
        b_res_valid = 1'b0;
    endtask

    task automatic drain_a(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (exp_a.size() == 0 && !a_out && a_idle) break;
            tick(1);
        end
        if (i == limit) check("a_drain_timeout", exp_a.size(), 0);
        tick(3);
    endtask

    task automatic drain_b(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (exp_b.size() == 0 && !b_out && b_idle) break;
            tick(1);
        end
        if (i == limit) check("b_drain_timeout", exp_b.size(), 0);
        tick(3);
    endtask

    task automatic wait_bytes_a(input int target, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (a_bytes >= target) break;
            tick(1);
        end
        if (i == limit) check("a_start_timeout", a_bytes, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        reset = 1'b1;
        tick(3);
        check("rst_tx_data",  a_tx_data, 8'h00);
        check("rst_tx_start", a_tx_start, 1'b0);
        check("rst_count",    a_fifo_count, 4'd0);
        check("rst_overflow", a_overflow, 1'b0);
        check("rst_idle",     a_idle, 1'b1);
        reset = 1'b0;
        tick(2);

        // single frame, LSB first with header; first start two edges after pop
        drive_a(21'h12ABCD, 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("a_latency_start", a_tx_start, 1'b1);
        check("a_latency_data",  a_tx_data, 8'hA5);
        drain_a(200);
        check("a_single_bytes", a_bytes, 4);
        check("a_single_idle",  a_idle, 1'b1);

        // MSB first without header
        drive_b(21'h12ABCD);
        drain_b(200);
        check("b_bytes", b_bytes, 3);
        check("b_idle",  b_idle, 1'b1);

        // back-to-back burst against a slow transmitter
        a_delay = 100;
        a_peak  = 0;
        base    = a_bytes;
        for (int i = 1; i <= 8; i++) drive_a(RW'(i), 1);
        check("a_burst_count", a_fifo_count, 4'd7);
        drain_a(6000);
        check("a_burst_bytes",    a_bytes - base, 32);
        check("a_burst_peak",     a_peak >= 7, 1'b1);
        check("a_burst_overflow", a_overflow, 1'b0);

        // overflow while the transmitter is stalled mid-frame
        a_delay = 3;
        a_stall = 1;
        base    = a_bytes;
        drive_a(21'h1FFFFF, 1);
        tick(5);
        check("a_ovf_popped", a_fifo_count, 4'd0);
        for (int i = 1; i <= 10; i++) drive_a(RW'(21'h100 + i), i <= 8);
        check("a_ovf_count", a_fifo_count, 4'd8);
        check("a_ovf_flag",  a_overflow, 1'b1);
        a_stall = 0;
        drain_a(3000);
        check("a_ovf_bytes",  a_bytes - base, 36);
        check("a_ovf_sticky", a_overflow, 1'b1);

        // spurious tx_done while idle
        base   = a_bytes;
        a_spur = 1'b1;
        tick(1);
        a_spur = 1'b0;
        tick(6);
        check("a_spur_idle_bytes", a_bytes - base, 0);
        check("a_spur_idle",       a_idle, 1'b1);

        // tx_done held an extra cycle after a data byte completes
        a_delay = 6;
        base    = a_bytes;
        drive_a(21'h0A55C3, 1);
        wait_bytes_a(base + 2, 200);
        a_dbl = 1;
        drain_a(400);
        check("a_dbl_bytes", a_bytes - base, 4);

        // asynchronous reset in WAIT_B of the second data byte
        a_delay = 10;
        base    = a_bytes;
        drive_a(21'h13579B, 1);
        wait_bytes_a(base + 3, 400);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        exp_a.delete();
        check("mid_rst_tx_start", a_tx_start, 1'b0);
        check("mid_rst_tx_data",  a_tx_data, 8'h00);
        check("mid_rst_count",    a_fifo_count, 4'd0);
        check("mid_rst_overflow", a_overflow, 1'b0);
        check("mid_rst_idle",     a_idle, 1'b1);
        tick(2);
        reset = 1'b0;
        tick(2);
        base = a_bytes;
        drive_a(21'h000077, 1);
        drain_a(400);
        check("a_post_rst_bytes", a_bytes - base, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
